// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl_pkg
// Description : Shared types and geometry constants for the cache line
//               refill controller (state encoding, set/beat/offset widths).
// Revision    : 1.0 - initial release
// ============================================================================
package cache_refill_ctrl_pkg;

  // Default cache geometry
  localparam int unsigned DEF_SETS       = 32;
  localparam int unsigned DEF_WAYS       = 4;
  localparam int unsigned DEF_LINE_BEATS = 4;
  localparam int unsigned DEF_ADDR_WID   = 32;
  localparam int unsigned DEF_DATA_WID   = 64;

  // Derived field widths for the default geometry
  localparam int unsigned SET_WID    = $clog2(DEF_SETS);
  localparam int unsigned BEAT_WID   = $clog2(DEF_LINE_BEATS);
  localparam int unsigned OFFSET_WID = $clog2(DEF_LINE_BEATS * DEF_DATA_WID / 8);

  // Refill sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_CAP  = 3'd2,
    ST_REQ  = 3'd3,
    ST_RESP = 3'd4,
    ST_DONE = 3'd5
  } refill_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : refill_victim_sel
// Description : Sanitises the replacement unit's victim vector into a strict
//               one-hot: keeps the lowest set bit, falls back to way 0 when
//               no bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module refill_victim_sel
  import cache_refill_ctrl_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic [WAYS-1:0] i_replace_vec,
  output logic [WAYS-1:0] o_victim_vec
);

  localparam logic [WAYS-1:0] c_ONE = WAYS'(1);

  logic [WAYS-1:0] w_lowest;

  // Two's-complement trick isolates the least significant set bit
  assign w_lowest     = i_replace_vec & (~i_replace_vec + c_ONE);
  assign o_victim_vec = (i_replace_vec == '0) ? c_ONE : w_lowest;

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Cache miss refill sequencer. Accepts one miss, obtains a
//               victim way from the external replacement unit, fetches the
//               line from memory beat by beat into the data array, then
//               writes the tag and updates the replacement state.
//               Optional critical-beat forwarding: CACHE_REFILL_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS,
  parameter int LINE_BEATS = DEF_LINE_BEATS,
  parameter int ADDR_WID   = DEF_ADDR_WID,
  parameter int DATA_WID   = DEF_DATA_WID
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_miss_vld,
  output logic                          o_miss_rdy,
  input  logic [ADDR_WID-1:0]           i_miss_addr,
  output logic [$clog2(SETS)-1:0]       o_plru_setIdx,
  input  logic [WAYS-1:0]               i_replace_vec,
  output logic                          o_plru_update_req,
  output logic [WAYS-1:0]               o_plru_wayhit_vec,
  output logic                          o_mem_req_vld,
  input  logic                          i_mem_req_rdy,
  output logic [ADDR_WID-1:0]           o_mem_req_addr,
  input  logic                          i_mem_resp_vld,
  input  logic [DATA_WID-1:0]           i_mem_resp_data,
  output logic                          o_arr_wen,
  output logic [WAYS-1:0]               o_arr_way_vec,
  output logic [$clog2(SETS)-1:0]       o_arr_setIdx,
  output logic [$clog2(LINE_BEATS)-1:0] o_arr_beat,
  output logic [DATA_WID-1:0]           o_arr_wdata,
  output logic                          o_tag_wen,
  output logic                          o_refill_done,
`ifdef CACHE_REFILL_FWD_EN
  output logic                          o_fwd_vld,
  output logic [DATA_WID-1:0]           o_fwd_data,
`endif
  output logic                          o_busy
);

  localparam int c_SET_W  = $clog2(SETS);
  localparam int c_BEAT_W = $clog2(LINE_BEATS);
  localparam int c_BYTE_W = $clog2(DATA_WID / 8);
  localparam int c_OFF_W  = $clog2(LINE_BEATS * DATA_WID / 8);

  localparam logic [ADDR_WID-1:0] c_LINE_MASK =
    {{(ADDR_WID - c_OFF_W){1'b1}}, {c_OFF_W{1'b0}}};
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_BEATS - 1);

  refill_state_e         r_state;
  logic [ADDR_WID-1:0]   r_addr;
  logic [WAYS-1:0]       r_victim;
  logic [c_BEAT_W-1:0]   r_beat;
  logic                  r_miss_rdy;
  logic                  r_busy;
  logic                  r_mem_req_vld;
  logic                  r_done;
  logic [WAYS-1:0]       w_victim;
  logic                  w_beat_wr;
  logic [c_SET_W-1:0]    w_set;

  refill_victim_sel #(
    .WAYS (WAYS)
  ) u_victim_sel (
    .i_replace_vec (i_replace_vec),
    .o_victim_vec  (w_victim)
  );

  // Miss address is only meaningful while a refill is in flight; no reset
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && i_miss_vld) begin
      r_addr <= i_miss_addr;
    end
  end

  // Refill sequencer with registered handshake and strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_victim      <= '0;
      r_miss_rdy    <= 1'b1;
      r_busy        <= 1'b0;
      r_mem_req_vld <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_miss_vld) begin
            r_state    <= ST_SEL;
            r_miss_rdy <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SEL: begin
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          r_victim      <= w_victim;
          r_state       <= ST_REQ;
          r_mem_req_vld <= 1'b1;
        end
        ST_REQ: begin
          if (i_mem_req_rdy) begin
            r_mem_req_vld <= 1'b0;
            r_beat        <= '0;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_mem_resp_vld) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_LAST_BEAT) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_miss_rdy <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_miss_rdy    <= 1'b1;
          r_busy        <= 1'b0;
          r_mem_req_vld <= 1'b0;
        end
      endcase
    end
  end

  // Beats land in the array in the same cycle they arrive from memory
  assign w_beat_wr = (r_state == ST_RESP) && i_mem_resp_vld;
  assign w_set     = r_addr[c_OFF_W +: c_SET_W];

  assign o_miss_rdy        = r_miss_rdy;
  assign o_busy            = r_busy;
  assign o_plru_setIdx     = w_set;
  assign o_mem_req_vld     = r_mem_req_vld;
  assign o_mem_req_addr    = r_addr & c_LINE_MASK;
  assign o_arr_wen         = w_beat_wr;
  assign o_arr_way_vec     = r_victim;
  assign o_arr_setIdx      = w_set;
  assign o_arr_beat        = r_beat;
  assign o_arr_wdata       = i_mem_resp_data;
  assign o_tag_wen         = r_done;
  assign o_refill_done     = r_done;
  assign o_plru_update_req = r_done;
  assign o_plru_wayhit_vec = r_victim;

`ifdef CACHE_REFILL_FWD_EN
  // Forward the beat holding the originally requested word
  assign o_fwd_vld  = w_beat_wr && (r_beat == r_addr[c_BYTE_W +: c_BEAT_W]);
  assign o_fwd_data = i_mem_resp_data;
`endif

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters: SETS=32 (cache sets); WAYS=4 (ways, >=2, power of 2); LINE_BEATS=4 (memory beats per line, power of 2); ADDR_WID=32 (byte address width); DATA_WID=64 (beat width).
REQ-002 Ports, one per line, as name direction width meaning:
- clk in 1: sole clock.
- rst in 1: asynchronous, active-high reset.
- i_miss_vld in 1: miss request valid.
- o_miss_rdy out 1: controller can accept a miss.
- i_miss_addr in ADDR_WID: miss byte address.
- o_plru_setIdx out clog2(SETS): set index presented to the replacement unit.
- i_replace_vec in WAYS: victim one-hot from the replacement unit, valid one cycle after o_plru_setIdx.
- o_plru_update_req out 1: replacement-unit update strobe.
- o_plru_wayhit_vec out WAYS: way to mark most-recently-used.
- o_mem_req_vld out 1: line fetch request valid.
- i_mem_req_rdy in 1: memory accepts the request.
- o_mem_req_addr out ADDR_WID: line-aligned fetch address.
- i_mem_resp_vld in 1: response beat valid.
- i_mem_resp_data in DATA_WID: response beat data.
- o_arr_wen out 1: data-array write enable.
- o_arr_way_vec out WAYS: data-array write way.
- o_arr_setIdx out clog2(SETS): data-array write set.
- o_arr_beat out clog2(LINE_BEATS): data-array beat index.
- o_arr_wdata out DATA_WID: data-array write data.
- o_tag_wen out 1: tag/valid write for the victim way.
- o_refill_done out 1: refill complete, one-cycle pulse.
- o_busy out 1: refill in progress.

Function
REQ-003 States: IDLE, SEL, CAP, REQ, RESP, DONE; o_miss_rdy=1 only in IDLE.
REQ-004 Miss accepted when i_miss_vld&o_miss_rdy at cycle T: latch address, set index = addr bits above line offset; go to SEL at T+1.
REQ-005 SEL: o_plru_setIdx = latched set; next state CAP. o_plru_setIdx holds the latched set in every non-IDLE state.
REQ-006 CAP: capture i_replace_vec as victim; if it is all-zero or not one-hot, the lowest set bit is used, and way 0 is used when all-zero; next state REQ.
REQ-007 REQ: o_mem_req_vld=1 with o_mem_req_addr = latched address with the offset bits zeroed; held stable until i_mem_req_rdy, then go to RESP.
REQ-008 RESP: each i_mem_resp_vld beat drives o_arr_wen=1 in the same cycle; o_arr_wdata is the beat data, o_arr_beat is the beat counter, o_arr_way_vec is the victim, o_arr_setIdx is the latched set.
REQ-009 The beat counter starts at 0, increments per beat and wraps modulo LINE_BEATS; on beat LINE_BEATS-1 go to DONE; beats outside RESP are ignored.
REQ-010 DONE (one cycle): o_tag_wen=1, o_refill_done=1, o_plru_update_req=1, o_plru_wayhit_vec=victim; next state IDLE.
REQ-011 o_busy = (state != IDLE); i_miss_vld while busy has no effect.
REQ-012 The earliest back-to-back accept is the cycle after DONE; minimum refill latency is accept + 4 + LINE_BEATS cycles with zero memory stalls.

Reset
REQ-013 rst asserted at any time, including mid-refill: state=IDLE, counter=0, victim=0; all strobes and valids are 0, o_miss_rdy=1 and o_busy=0 during reset; no partial tag write occurs.
REQ-014 Data and address registers carry no reset requirement; they are don't-care while their qualifying strobe is 0.

Configuration
REQ-015 Macro CACHE_REFILL_FWD_EN: when defined, add outputs o_fwd_vld (1) and o_fwd_data (DATA_WID); o_fwd_vld pulses in the same cycle as the beat whose index equals the miss address beat offset, and o_fwd_data carries that beat.
REQ-016 When CACHE_REFILL_FWD_EN is undefined, these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-017 A shared package holds the state enum and the localparams SET_WID=clog2(SETS), BEAT_WID=clog2(LINE_BEATS) and OFFSET_WID=clog2(LINE_BEATS*DATA_WID/8).
REQ-018 One sub-module, refill_victim_sel, implements the combinational one-hot sanitize of REQ-006; the replacement unit stays external.

Verification
REQ-019 Single miss, addr=0x1040, replace_vec=0b0100, rdy immediate, 4 beats -> mem addr 0x1040, 4 writes beat 0..3 to way 0b0100 at set 2, DONE pulse with update way 0b0100.
REQ-020 replace_vec=0b0000 -> victim 0b0001; replace_vec=0b0110 -> victim 0b0010.
REQ-021 i_mem_req_rdy low for 3 cycles -> request and address held stable, no array writes.
REQ-022 i_miss_vld held during refill -> o_miss_rdy=0, second miss accepted the cycle after DONE.
REQ-023 rst asserted after beat 1 -> IDLE next cycle, no o_tag_wen or o_refill_done; a fresh miss then completes normally.
REQ-024 With CACHE_REFILL_FWD_EN, addr offset beat 2 -> o_fwd_vld exactly on beat 2 with matching data.
